mcash_chn_resp: RTL and testbench
=================================

// Module: mcash_chn_resp
// PURPOSE
//  Responder end of one mcash channel req/rtn interface: accepts req beats (valid/allowIn), services them
//  against a local line store, and returns exactly one rtn beat per accepted request (valid/ready).
//  Used as the memory-side model behind each mcash channel and as a standalone channel endpoint in the sim tree.
//  Strict in-order: rtn beats leave in request-accept order.
// PARAMETERS
//  IDX_W      6  line-index width; store depth = 2**IDX_W lines of 128 bits
//  RTN_DEPTH  4  return-queue entries; also max outstanding requests (credit limit), >=2
// PORTS
//  clk_i            in   1       clock, all state on posedge
//  rst_i            in   1       asynchronous reset, active-low
//  req_valid_i      in   1       request present
//  req_allowIn_o    out  1       responder can accept this cycle
//  req_op_i         in   3       0=READ 1=WRITE 2=FLUSH 3..7=NOP
//  req_addr_i       in   28      line address [31:4]; index = req_addr_i[IDX_W-1:0], upper bits aliased
//  req_data_i       in   128     write data (WRITE only)
//  rtn_valid_o      out  1       return beat present
//  rtn_ready_i      in   1       consumer accepts return beat
//  rtn_data_o       out  128     return data
// BEHAVIOUR
//  Reset: allowIn=0 while rst_i low, =1 first cycle after release; rtn_valid=0, rtn_data=0; FSM=IDLE;
//   queue/pipe empty; store contents NOT reset (bench must FLUSH before relying on zeros).
//  Accept = req_valid_i & req_allowIn_o at posedge. Transfer = rtn_valid_o & rtn_ready_i at posedge.
//  allowIn = (state==IDLE) & (outstanding < RTN_DEPTH); outstanding = s1_valid + queue count, registered only;
//   a transfer in the same cycle does NOT free a credit until the next cycle.
//  READ: store read at accept edge into stage s1; s1 pushes to queue next edge; rtn_valid high 2 cycles
//   after accept when queue empty. Data = line at accept time (write accepted earlier is visible).
//  WRITE: store[idx] <= req_data_i at accept edge; rtn beat data = 128'h0 (ack), same 2-cycle latency.
//  NOP: no store access; rtn beat data = 128'h0.
//  FLUSH: FSM IDLE->FLUSH on accept; allowIn=0 from next cycle; writes 0 to index 0..2**IDX_W-1, one per
//   cycle (counter flush_idx); at last index pushes rtn beat data = {96'h0, 32'(2**IDX_W)} and returns to IDLE.
//   Credit for the flush beat is reserved at accept; earlier READs already hold pre-flush data.
//  Queue full: never overflows (credit rule); rtn_data_o/rtn_valid_o hold stable while valid & !ready.
//  Simultaneous push+pop: count unchanged, order preserved. Pointers wrap modulo RTN_DEPTH.
//  rst_i asserted mid-operation: queue, s1, FSM and flush_idx cleared immediately; pending beats dropped.
// CONFIGURATION
//  MCASH_RESP_PERF_EN defined: extra outputs perf_req_cnt_o[31:0] (accepts) and perf_stall_cnt_o[31:0]
//   (cycles rtn_valid & !rtn_ready), both reset 0, saturate at 32'hFFFF_FFFF.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package mcash_resp_pkg: op enum (OP_READ/OP_WRITE/OP_FLUSH), FSM enum (ST_IDLE/ST_FLUSH),
//   LINE_W=128, ADDR_W=28, flush-ack data constant function.
//  Sub-module mcash_resp_fifo: parameterised RTN_DEPTH x 128 FIFO, count output, no fall-through.
//  Top: accept logic, store array, s1 register, flush FSM/counter, optional perf counters.
// TESTING
//  1 WRITE addr 5 data 128'hA5..A5, then READ addr 5, ready=1 -> 2 beats: 0, then A5..A5; each 2 cycles post-accept.
//  2 rtn_ready=0, valid held, 6 READs -> exactly RTN_DEPTH=4 accepted, allowIn=0; release ready -> 4 beats in
//    order, allowIn=1 one cycle after first transfer.
//  3 WRITE addr 3, FLUSH, READ addr 3 -> allowIn=0 for 64 cycles, flush beat data=32'd64, READ returns 0.
//  4 READ addr 28'h0000040 after WRITE addr 0 data 1 (IDX_W=6) -> aliased, returns 1; op 5 -> NOP beat 0.
//  5 rst_i low mid-FLUSH with 2 beats queued -> rtn_valid=0 immediately, allowIn=1 first cycle after release.
//  6 MCASH_RESP_PERF_EN: 3 accepts, ready low 7 cycles while valid -> perf_req_cnt=3, perf_stall_cnt=7.

Source files
------------

// File: rtl/mcash_resp_pkg.sv
// Shared types and constants for the mcash channel responder.
//   op_e           request opcodes (codes 3..7 are NOPs and have no member)
//   state_e        responder FSM states
//   LINE_W/ADDR_W  line data width and line-address width
//   flush_ack_data data returned on the FLUSH beat: number of lines cleared
package mcash_resp_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [2:0] {
    OP_READ  = 3'd0,
    OP_WRITE = 3'd1,
    OP_FLUSH = 3'd2
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic [LINE_W-1:0] flush_ack_data(input int unsigned idx_w);
    logic [31:0] lines;
    lines = 32'd1 << idx_w;
    return {96'h0, lines};
  endfunction

endpackage

// File: rtl/mcash_resp_fifo.sv
// In-order return queue for the mcash responder.
//   clk_i/rst_i   clock, asynchronous active-low reset
//   push_i        write push_data_i at the tail (caller guarantees not full)
//   pop_i         drop the head entry (caller guarantees not empty)
//   valid_o       queue holds at least one entry
//   data_o        head entry, zero when empty; registered storage, no fall-through
//   count_o       number of stored entries, 0..DEPTH
module mcash_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; empty reads are masked to zero below.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/mcash_chn_resp.sv
// Responder end of one mcash channel: accepts req beats, services them
// against a local line store and returns exactly one rtn beat per accepted
// request, strictly in accept order.
//   clk_i, rst_i            clock, asynchronous active-low reset
//   req_valid_i/allowIn_o   request handshake
//   req_op_i                0=READ 1=WRITE 2=FLUSH 3..7=NOP
//   req_addr_i              line address; low IDX_W bits index the store
//   req_data_i              write data
//   rtn_valid_o/ready_i     return handshake
//   rtn_data_o              return data (READ line, 0 for WRITE/NOP, line count for FLUSH)
//   dbg_state_o             current FSM state
//   perf_req_cnt_o          accepts (only with MCASH_RESP_PERF_EN)
//   perf_stall_cnt_o        cycles rtn_valid & !rtn_ready (only with MCASH_RESP_PERF_EN)
// Optional feature macro: MCASH_RESP_PERF_EN.
//
// Handshakes: a req beat moves on a posedge where req_valid_i & req_allowIn_o;
// a rtn beat moves on a posedge where rtn_valid_o & rtn_ready_i. Once
// rtn_valid_o is high it and rtn_data_o hold until that beat moves.
module mcash_chn_resp
  import mcash_resp_pkg::*;
#(
  parameter int IDX_W     = 6,
  parameter int RTN_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_allowIn_o,
  input  logic [2:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LINE_W-1:0] req_data_i,
  output logic              rtn_valid_o,
  input  logic              rtn_ready_i,
  output logic [LINE_W-1:0] rtn_data_o,
  output state_e            dbg_state_o
`ifdef MCASH_RESP_PERF_EN
  ,
  output logic [31:0]       perf_req_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam int LINES = 2 ** IDX_W;
  localparam int CNT_W = $clog2(RTN_DEPTH + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LINES - 1);
  localparam logic [LINE_W-1:0] FLUSH_ACK = flush_ack_data(IDX_W);

  state_e              state_q;
  state_e              state_d;
  logic [IDX_W-1:0]    flush_idx_q;
  logic                flush_done;
  logic                s1_valid_q;
  logic [LINE_W-1:0]   s1_data_q;
  logic [LINE_W-1:0]   store [LINES];
  logic [IDX_W-1:0]    req_idx;
  logic                accept;
  logic                transfer;
  logic                is_read;
  logic                is_write;
  logic                is_flush;
  logic                push;
  logic [LINE_W-1:0]   push_data;
  logic [CNT_W-1:0]    q_count;
  logic [CNT_W-1:0]    outstanding;
  logic                addr_unused;

  // Upper address bits alias onto the same lines.
  assign req_idx     = req_addr_i[IDX_W-1:0];
  assign addr_unused = ^req_addr_i[ADDR_W-1:IDX_W];

  assign is_read  = (req_op_i == OP_READ);
  assign is_write = (req_op_i == OP_WRITE);
  assign is_flush = (req_op_i == OP_FLUSH);

  // Credits count only registered occupancy, so a beat leaving this cycle
  // frees its slot one cycle later. The flush beat needs no explicit
  // reservation: no request is accepted while flushing, so the slot free at
  // accept time stays free until the flush beat is pushed.
  assign outstanding   = q_count + CNT_W'(s1_valid_q);
  assign req_allowIn_o = rst_i & (state_q == ST_IDLE) &
                         (outstanding < CNT_W'(RTN_DEPTH));
  assign accept        = req_valid_i & req_allowIn_o;
  assign transfer      = rtn_valid_o & rtn_ready_i;

  // FSM
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_idx_q == IDX_LAST) begin
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

  // Flush counter wraps back to 0 on the last line, ready for the next flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                   flush_idx_q <= '0;
    else if (state_q == ST_FLUSH) flush_idx_q <= flush_idx_q + IDX_W'(1);
  end

  // Stage s1: captures the response at accept time, so a READ sees every
  // earlier WRITE and none of a later FLUSH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept & ~is_flush;
      if (accept && !is_flush) s1_data_q <= is_read ? store[req_idx] : '0;
    end
  end

  // Line store, intentionally not reset. Flush writes and request writes
  // never coincide because nothing is accepted outside ST_IDLE.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_FLUSH)      store[flush_idx_q] <= '0;
    else if (accept && is_write)  store[req_idx]     <= req_data_i;
  end

  // s1 and the flush completion never push in the same cycle: the flush
  // lasts at least two cycles and s1 drains on the first of them.
  assign push      = s1_valid_q | flush_done;
  assign push_data = s1_valid_q ? s1_data_q : FLUSH_ACK;

  mcash_resp_fifo #(
    .DEPTH (RTN_DEPTH),
    .W     (LINE_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (transfer),
    .valid_o     (rtn_valid_o),
    .data_o      (rtn_data_o),
    .count_o     (q_count)
  );

`ifdef MCASH_RESP_PERF_EN
  logic [31:0] perf_req_cnt_q;
  logic [31:0] perf_stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_req_cnt_q   <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      if (accept && perf_req_cnt_q != '1)
        perf_req_cnt_q <= perf_req_cnt_q + 32'd1;
      if (rtn_valid_o && !rtn_ready_i && perf_stall_cnt_q != '1)
        perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
    end
  end

  assign perf_req_cnt_o   = perf_req_cnt_q;
  assign perf_stall_cnt_o = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mcash_chn_resp.sv
module tb_mcash_chn_resp;
  import mcash_resp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          req_valid;
  logic          req_allowIn;
  logic [2:0]    req_op;
  logic [27:0]   req_addr;
  logic [127:0]  req_data;
  logic          rtn_valid;
  logic          rtn_ready;
  logic [127:0]  rtn_data;
  state_e        dbg_state;
`ifdef MCASH_RESP_PERF_EN
  logic [31:0]   perf_req_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  mcash_chn_resp #(.IDX_W(6), .RTN_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid),
    .req_allowIn_o (req_allowIn),
    .req_op_i      (req_op),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .rtn_valid_o   (rtn_valid),
    .rtn_ready_i   (rtn_ready),
    .rtn_data_o    (rtn_data),
    .dbg_state_o   (dbg_state)
`ifdef MCASH_RESP_PERF_EN
    ,
    .perf_req_cnt_o   (perf_req_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  localparam logic [127:0] D_A5   = {16{8'hA5}};
  localparam logic [127:0] D_DEAD = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] D_55   = {4{32'h5555_1234}};
  localparam logic [127:0] D_77   = {4{32'h7777_0003}};
  localparam logic [127:0] D_ONES = {128{1'b1}};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // A beat seen valid & ready at negedge moves on the following posedge.
  always @(negedge clk) begin
    if (rst_i && rtn_valid && rtn_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got=%0h exp=none", rtn_data);
      end else begin
        check("rtn_data", rtn_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [27:0] addr,
                      input logic [127:0] data, input logic [127:0] exp);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    while (!req_allowIn && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_allowIn) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=allowIn_low exp=accept op=%0d", op);
    end else begin
      exp_q.push_back(exp);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]   op;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic took;
    logic [27:0]  t2_addr[6];
    logic [127:0] t2_exp[6];

    vecs[0]  = '{3'd1, 28'h0000005, D_A5,   128'h0};
    vecs[1]  = '{3'd0, 28'h0000005, 128'h0, D_A5};
    vecs[2]  = '{3'd1, 28'h0000000, 128'h1, 128'h0};
    vecs[3]  = '{3'd0, 28'h0000040, 128'h0, 128'h1};
    vecs[4]  = '{3'd5, 28'h0000007, D_ONES, 128'h0};
    vecs[5]  = '{3'd0, 28'h0000007, 128'h0, 128'h0};
    vecs[6]  = '{3'd1, 28'hABCDE3F, D_DEAD, 128'h0};
    vecs[7]  = '{3'd0, 28'h000003F, 128'h0, D_DEAD};
    vecs[8]  = '{3'd7, 28'h0000000, D_ONES, 128'h0};
    vecs[9]  = '{3'd0, 28'hFFFFFC5, 128'h0, D_A5};
    vecs[10] = '{3'd0, 28'h0000000, 128'h0, 128'h1};
    vecs[11] = '{3'd3, 28'h000003F, 128'h0, 128'h0};
    vecs[12] = '{3'd0, 28'h000003F, 128'h0, D_DEAD};

    t2_addr = '{28'd5, 28'd0, 28'd63, 28'd7, 28'd5, 28'd0};
    t2_exp  = '{D_A5, 128'h1, D_DEAD, 128'h0, D_A5, 128'h1};

    rst_i     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = '0;
    req_data  = '0;
    rtn_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_allowIn",   req_allowIn, 0);
    check("reset_rtn_valid", rtn_valid,   0);
    check("reset_rtn_data",  rtn_data,    0);
    check("reset_state",     dbg_state,   ST_IDLE);
    @(posedge clk); #3;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("release_allowIn", req_allowIn, 1);

    // Clear the store before relying on zeros
    rtn_ready = 1'b1;
    send(OP_FLUSH, 28'h0, 128'h0, 128'd64);
    wait_drain();

    // Table-driven back-to-back traffic
    for (int i = 0; i < 13; i++) send(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp);
    wait_drain();

    // Two-cycle return latency for WRITE then READ
    req_valid = 1'b1; req_op = OP_WRITE; req_addr = 28'd9; req_data = D_55;
    check("lat_allowIn", req_allowIn, 1);
    exp_q.push_back(128'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lat_wr_e0_valid", rtn_valid, 0);
    @(posedge clk); #1;
    check("lat_wr_e1_valid", rtn_valid, 1);
    check("lat_wr_e1_data",  rtn_data,  0);
    req_valid = 1'b1; req_op = OP_READ; req_data = '0;
    exp_q.push_back(D_55);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("lat_rd_e0_valid", rtn_valid, 0);
    @(posedge clk); #1;
    check("lat_rd_e1_valid", rtn_valid, 1);
    check("lat_rd_e1_data",  rtn_data,  D_55);
    wait_drain();

    // Back-pressure: credit limit of 4 with valid held for 6 cycles
    rtn_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = OP_READ;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = t2_addr[acc];
      took = req_allowIn;
      if (took) exp_q.push_back(t2_exp[acc]);
      @(posedge clk); #1;
      if (took) acc++;
    end
    req_valid = 1'b0;
    check("bp_accepts", acc, 4);
    check("bp_allowIn_full", req_allowIn, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", rtn_valid, 1);
    check("bp_hold_data",  rtn_data,  D_A5);
    rtn_ready = 1'b1;
    check("bp_allowIn_xfer_cycle", req_allowIn, 0);
    @(posedge clk); #1;
    check("bp_allowIn_after_xfer", req_allowIn, 1);
    wait_drain();

    // FLUSH: earlier READ keeps old data, store cleared afterwards
    send(OP_WRITE, 28'd3, D_77, 128'h0);
    send(OP_READ,  28'd3, 128'h0, D_77);
    send(OP_FLUSH, 28'h0, 128'h0, 128'd64);
    check("flush_state", dbg_state, ST_FLUSH);
    n = 0;
    while (!req_allowIn && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("flush_allowIn_low_cycles", n, 64);
    check("flush_back_idle", dbg_state, ST_IDLE);
    send(OP_READ, 28'd3, 128'h0, 128'h0);
    send(OP_READ, 28'd5, 128'h0, 128'h0);
    send(OP_READ, 28'd63, 128'h0, 128'h0);
    wait_drain();

    // Reset in the middle of a FLUSH with beats queued
    rtn_ready = 1'b0;
    send(OP_READ, 28'd3, 128'h0, 128'h0);
    send(OP_READ, 28'd9, 128'h0, 128'h0);
    send(OP_FLUSH, 28'h0, 128'h0, 128'd64);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_valid", rtn_valid, 1);
    check("pre_reset_state", dbg_state, ST_FLUSH);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_rtn_valid", rtn_valid,   0);
    check("midrst_rtn_data",  rtn_data,    0);
    check("midrst_allowIn",   req_allowIn, 0);
    check("midrst_state",     dbg_state,   ST_IDLE);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_allowIn", req_allowIn, 1);
    check("midrst_release_valid",   rtn_valid,   0);

    // Three NOPs under back-pressure held for seven stalled cycles
    send(3'd5, 28'd1, 128'h0, 128'h0);
    send(3'd5, 28'd2, 128'h0, 128'h0);
    send(3'd6, 28'd3, 128'h0, 128'h0);
    repeat (6) @(posedge clk);
    #1;
    rtn_ready = 1'b1;
    wait_drain();
`ifdef MCASH_RESP_PERF_EN
    check("perf_req_cnt",   perf_req_cnt,   3);
    check("perf_stall_cnt", perf_stall_cnt, 7);
`endif

    // Final write/read after reset
    send(OP_WRITE, 28'd12, D_A5, 128'h0);
    send(OP_READ,  28'd12, 128'h0, D_A5);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
